input_neuron_array: RTL and testbench
=====================================

INPUT_NEURON_ARRAY -- requirements
Module: input_neuron_array

Interface
REQ-001 SHALL provide parameter N, default 16, number of input channels (1..64).
REQ-002 SHALL provide parameter CW, default 8, per-channel counter width.
REQ-003 SHALL provide parameter TMAX, default 21, counter saturation value; TMAX SHALL be less than or equal to 2^CW-1.
REQ-004 SHALL provide parameter T_STEPS, default 32, time steps per image (at least 2).
REQ-005 SHALL provide port clk, input, 1 bit: clock, rising edge.
REQ-006 SHALL provide port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL provide port spike_in, input, N bits: raw input spikes, bit i is channel i.
REQ-008 SHALL provide port chan_en, input, N bits: channel enable mask; a 0 bit forces that channel's sampled spike to 0.
REQ-009 SHALL provide port start, input, 1 bit: time-step strobe.
REQ-010 SHALL provide port start_core_img, input, 1 bit: new-image strobe.
REQ-011 SHALL provide port spike_out, output, N bits: registered spike per channel.
REQ-012 SHALL provide port count, output, N*CW bits: channel i counter at bits [i*CW +: CW].
REQ-013 SHALL provide port fired_cnt, output, clog2(N+1) bits: number of 1 bits in spike_out.
REQ-014 SHALL provide port step_idx, output, clog2(T_STEPS) bits: current step within the image.
REQ-015 SHALL provide port done, output, 1 bit: one-cycle pulse acknowledging an accepted step.
REQ-016 SHALL provide port frame_done, output, 1 bit: one-cycle pulse when the last step of an image is accepted.

Function
REQ-017 A step is accepted on a rising clk edge where start=1, start_core_img=0 and the state is RUN.
REQ-018 On an accepted step, each channel i SHALL update spike_out[i] to spike_in[i] AND chan_en[i].
REQ-019 On an accepted step, counter i SHALL evaluate the pre-edge spike_out[i] (one-step delay): if it is 1, counter i becomes 0; otherwise, if the counter is below TMAX, it increments by 1; otherwise it holds at TMAX.
REQ-020 Counters SHALL never exceed TMAX and SHALL never wrap.
REQ-021 fired_cnt SHALL be registered and SHALL equal the popcount of the new spike_out value, updating in the same edge.
REQ-022 done SHALL be 1 for exactly the cycle following each accepted step and 0 otherwise.
REQ-023 The FSM SHALL have two states, RUN and HOLD.
REQ-024 In RUN, an accepted step SHALL increment step_idx; when step_idx equals T_STEPS-1, the step is accepted, step_idx holds at T_STEPS-1, frame_done pulses with done, and the state goes to HOLD.
REQ-025 In HOLD, start SHALL be ignored: no state change, done=0.
REQ-026 start_core_img=1 SHALL (any state, priority over start) set all counters to TMAX, clear spike_out and fired_cnt, set step_idx to 0, enter RUN, and keep done and frame_done at 0.
REQ-027 Simultaneous start and start_core_img SHALL behave as start_core_img alone.
REQ-028 All outputs except fired_cnt's combinational source SHALL be registered; no combinational path from inputs to outputs.
REQ-029 Behaviour of all N channels SHALL be identical and independent apart from the shared start, step_idx and FSM.

Reset
REQ-030 While rst=1 (asynchronous), spike_out=0, all counters=TMAX, fired_cnt=0, step_idx=0, done=0, frame_done=0, and the state is RUN.
REQ-031 Reset asserted mid-image SHALL abort the image; the first accepted step after release is step 0.

Verification
REQ-032 Reset and spike, N=4, TMAX=21, chan_en=1111: spike_in=0001 on step 0, then 0000 -> after step 0 spike_out=0001, count0=21; after step 1 count0=0; after steps 2..4 count0=1,2,3; other channels stay 21.
REQ-033 Saturation: start_core_img, then 30 steps with no spikes -> every counter remains 21; done pulses 30 times.
REQ-034 Mask: spike_in=1111, chan_en=0101 -> spike_out=0101, fired_cnt=2; the next step leaves count1 and count3 at TMAX.
REQ-035 Frame end, T_STEPS=4: 6 start pulses -> frame_done on the 4th only, step_idx=3, starts 5 and 6 produce no done; start_core_img -> step_idx=0 and RUN, and the next start gives done.
REQ-036 Collision: start and start_core_img in the same cycle with spike_in=1111 -> spike_out=0, counters=TMAX, done=0.
REQ-037 Async reset asserted between clock edges at step 2 -> outputs go to reset values immediately without a clock edge; after release, the first step gives step_idx=1.

Source files
------------

// File: rtl/input_neuron_array.sv
// input_neuron_array: per-channel spike sampling with time-since-last-spike counters, stepped per image.
module input_neuron_array #(
    parameter int N       = 16,
    parameter int CW      = 8,
    parameter int TMAX    = 21,
    parameter int T_STEPS = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N-1:0]                 spike_in,
    input  logic [N-1:0]                 chan_en,
    input  logic                         start,
    input  logic                         start_core_img,
    output logic [N-1:0]                 spike_out,
    output logic [N*CW-1:0]              count,
    output logic [$clog2(N+1)-1:0]       fired_cnt,
    output logic [$clog2(T_STEPS)-1:0]   step_idx,
    output logic                         done,
    output logic                         frame_done
);
    localparam int FW = $clog2(N+1);
    localparam int SW = $clog2(T_STEPS);
    localparam logic [CW-1:0] TM = CW'(TMAX);
    localparam logic [SW-1:0] LAST = SW'(T_STEPS - 1);

    typedef enum logic {RUN, HOLD} state_t;

    state_t               r_state, w_next;
    logic                 w_accept, w_last;
    logic [N-1:0]         w_spike_next;
    logic [FW-1:0]        w_pop;
    logic [N-1:0]         r_spike;
    logic [N-1:0][CW-1:0] r_cnt;
    logic [FW-1:0]        r_fired;
    logic [SW-1:0]        r_step;
    logic                 r_done, r_frame;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = start_core_img ? RUN : (w_accept && w_last) ? HOLD : r_state;
    end

    always_comb begin
        w_accept = start && !start_core_img && (r_state == RUN);
        w_last   = (r_step == LAST);
    end

    always_comb begin
        w_spike_next = spike_in & chan_en;
        w_pop = '0;
        for (int k = 0; k < N; k++) w_pop = w_pop + FW'(w_spike_next[k]);
    end

    // Counters look at the previous step's spike, so a spike resets its counter one step later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || start_core_img) begin
            r_spike <= '0;
            r_cnt   <= {N{TM}};
            r_fired <= '0;
            r_step  <= '0;
            r_done  <= 1'b0;
            r_frame <= 1'b0;
        end else begin
            r_done  <= w_accept;
            r_frame <= w_accept && w_last;
            if (w_accept) begin
                r_spike <= w_spike_next;
                r_fired <= w_pop;
                if (!w_last) r_step <= r_step + SW'(1);
                for (int k = 0; k < N; k++)
                    r_cnt[k] <= r_spike[k] ? '0 : (r_cnt[k] < TM) ? r_cnt[k] + CW'(1) : TM;
            end
        end
    end

    assign spike_out  = r_spike;
    assign count      = r_cnt;
    assign fired_cnt  = r_fired;
    assign step_idx   = r_step;
    assign done       = r_done;
    assign frame_done = r_frame;
endmodule

// File: tb/tb_input_neuron_array.sv
// tb_input_neuron_array: scenario tasks plus randomized run against a behavioural model.
module tb_input_neuron_array;
    localparam int N = 4, CW = 8, TMAX = 21, T = 32, TF = 4;

    logic clk = 1'b0, rst = 1'b1;
    logic [N-1:0] spike_in = '0, chan_en = '0;
    logic start = 1'b0, sci = 1'b0;

    logic [N-1:0] spike_out, f_spike;
    logic [N*CW-1:0] count, f_count;
    logic [2:0] fired_cnt, f_fired;
    logic [4:0] step_idx;
    logic [1:0] f_step_idx;
    logic done, frame_done, f_done, f_frame;

    int checks = 0, failures = 0;

    int m_cnt[N];
    logic [N-1:0] m_spike;
    int m_step, f_step;
    bit m_hold, f_hold;
    logic e_done, e_frame, ef_done, ef_frame;

    input_neuron_array #(.N(N), .CW(CW), .TMAX(TMAX), .T_STEPS(T)) dut (
        .clk(clk), .rst(rst), .spike_in(spike_in), .chan_en(chan_en), .start(start),
        .start_core_img(sci), .spike_out(spike_out), .count(count), .fired_cnt(fired_cnt),
        .step_idx(step_idx), .done(done), .frame_done(frame_done));

    input_neuron_array #(.N(N), .CW(CW), .TMAX(TMAX), .T_STEPS(TF)) dut_f (
        .clk(clk), .rst(rst), .spike_in(spike_in), .chan_en(chan_en), .start(start),
        .start_core_img(sci), .spike_out(f_spike), .count(f_count), .fired_cnt(f_fired),
        .step_idx(f_step_idx), .done(f_done), .frame_done(f_frame));

    always #5 clk = ~clk;

    function automatic logic [N*CW-1:0] exp_count();
        logic [N*CW-1:0] v;
        for (int i = 0; i < N; i++) v[i*CW +: CW] = CW'(m_cnt[i]);
        return v;
    endfunction

    function automatic int cnt_of(input logic [N*CW-1:0] c, input int i);
        return int'(c[i*CW +: CW]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = TMAX;
        m_spike = '0; m_step = 0; m_hold = 0; f_step = 0; f_hold = 0;
        e_done = 0; e_frame = 0; ef_done = 0; ef_frame = 0;
    endtask

    task automatic tick(input logic st, input logic sc, input logic [N-1:0] sp, input logic [N-1:0] en);
        start = st; sci = sc; spike_in = sp; chan_en = en;
        @(posedge clk);
        if (sc) model_reset();
        else begin
            e_done = st && !m_hold;
            e_frame = e_done && (m_step == T - 1);
            if (e_done) begin
                for (int i = 0; i < N; i++)
                    m_cnt[i] = m_spike[i] ? 0 : (m_cnt[i] < TMAX ? m_cnt[i] + 1 : TMAX);
                m_spike = sp & en;
                if (m_step == T - 1) m_hold = 1; else m_step++;
            end
            ef_done = st && !f_hold;
            ef_frame = ef_done && (f_step == TF - 1);
            if (ef_done) begin
                if (f_step == TF - 1) f_hold = 1; else f_step++;
            end
        end
        @(negedge clk);
        start = 1'b0; sci = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        @(negedge clk);
        checks++; if (spike_out !== '0) begin failures++; $display("FAIL reset_spike got=%b exp=0", spike_out); end
        checks++; if (count !== {N{8'd21}}) begin failures++; $display("FAIL reset_count got=%h exp=%h", count, {N{8'd21}}); end
        checks++; if (fired_cnt !== 3'd0 || step_idx !== 5'd0) begin failures++; $display("FAIL reset_fired_step got=%0d/%0d exp=0/0", fired_cnt, step_idx); end
        checks++; if (done !== 1'b0 || frame_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b%b exp=00", done, frame_done); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_spike();
        tick(0, 1, '0, '1);
        tick(1, 0, 4'b0001, 4'b1111);
        checks++; if (spike_out !== 4'b0001 || cnt_of(count, 0) != 21) begin failures++; $display("FAIL spike_step0 got=%b/%0d exp=0001/21", spike_out, cnt_of(count, 0)); end
        checks++; if (done !== 1'b1 || step_idx !== 5'd1) begin failures++; $display("FAIL spike_done0 got=%b/%0d exp=1/1", done, step_idx); end
        tick(1, 0, 4'b0000, 4'b1111);
        checks++; if (cnt_of(count, 0) != 0) begin failures++; $display("FAIL spike_step1 got=%0d exp=0", cnt_of(count, 0)); end
        for (int s = 2; s <= 4; s++) begin
            tick(1, 0, 4'b0000, 4'b1111);
            checks++; if (cnt_of(count, 0) != s - 1) begin failures++; $display("FAIL spike_step%0d got=%0d exp=%0d", s, cnt_of(count, 0), s - 1); end
        end
        checks++; if (count[N*CW-1:CW] !== {3{8'd21}}) begin failures++; $display("FAIL spike_others got=%h exp=151515", count[N*CW-1:CW]); end
    endtask

    task automatic test_saturation();
        int pulses = 0;
        tick(0, 1, '0, '1);
        for (int s = 0; s < 30; s++) begin
            tick(1, 0, 4'b0000, 4'b1111);
            if (done === 1'b1) pulses++;
            checks++; if (count !== {N{8'd21}}) begin failures++; $display("FAIL sat_count step=%0d got=%h exp=%h", s, count, {N{8'd21}}); end
        end
        checks++; if (pulses != 30) begin failures++; $display("FAIL sat_done_pulses got=%0d exp=30", pulses); end
    endtask

    task automatic test_mask();
        tick(0, 1, '0, '1);
        tick(1, 0, 4'b1111, 4'b0101);
        checks++; if (spike_out !== 4'b0101 || fired_cnt !== 3'd2) begin failures++; $display("FAIL mask_out got=%b/%0d exp=0101/2", spike_out, fired_cnt); end
        tick(1, 0, 4'b0000, 4'b1111);
        checks++; if (cnt_of(count, 1) != TMAX || cnt_of(count, 3) != TMAX) begin failures++; $display("FAIL mask_count got=%0d/%0d exp=21/21", cnt_of(count, 1), cnt_of(count, 3)); end
        checks++; if (cnt_of(count, 0) != 0 || cnt_of(count, 2) != 0) begin failures++; $display("FAIL mask_fired_count got=%0d/%0d exp=0/0", cnt_of(count, 0), cnt_of(count, 2)); end
    endtask

    task automatic test_frame();
        tick(0, 1, '0, '1);
        for (int s = 1; s <= 6; s++) begin
            tick(1, 0, 4'b0000, 4'b1111);
            checks++; if (f_done !== (s <= 4) || f_frame !== (s == 4)) begin failures++; $display("FAIL frame_start%0d got=%b%b exp=%b%b", s, f_done, f_frame, s <= 4, s == 4); end
        end
        checks++; if (f_step_idx !== 2'd3) begin failures++; $display("FAIL frame_step got=%0d exp=3", f_step_idx); end
        tick(0, 1, '0, '1);
        checks++; if (f_step_idx !== 2'd0 || f_done !== 1'b0) begin failures++; $display("FAIL frame_restart got=%0d/%b exp=0/0", f_step_idx, f_done); end
        tick(1, 0, 4'b0000, 4'b1111);
        checks++; if (f_done !== 1'b1 || f_step_idx !== 2'd1) begin failures++; $display("FAIL frame_after got=%b/%0d exp=1/1", f_done, f_step_idx); end
    endtask

    task automatic test_collision();
        tick(1, 0, 4'b1111, 4'b1111);
        tick(1, 1, 4'b1111, 4'b1111);
        checks++; if (spike_out !== '0 || count !== {N{8'd21}} || done !== 1'b0) begin failures++; $display("FAIL collision got=%b/%h/%b exp=0000/%h/0", spike_out, count, done, {N{8'd21}}); end
        checks++; if (step_idx !== 5'd0 || fired_cnt !== 3'd0 || frame_done !== 1'b0) begin failures++; $display("FAIL collision_misc got=%0d/%0d/%b exp=0/0/0", step_idx, fired_cnt, frame_done); end
    endtask

    task automatic test_async_reset();
        tick(0, 1, '0, '1);
        tick(1, 0, 4'b1010, 4'b1111);
        tick(1, 0, 4'b0110, 4'b1111);
        #2 rst = 1'b1;
        #1;
        checks++; if (spike_out !== '0 || count !== {N{8'd21}} || step_idx !== 5'd0) begin failures++; $display("FAIL async_rst got=%b/%h/%0d exp=0000/%h/0", spike_out, count, step_idx, {N{8'd21}}); end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        tick(1, 0, 4'b0000, 4'b1111);
        checks++; if (step_idx !== 5'd1 || done !== 1'b1) begin failures++; $display("FAIL async_after got=%0d/%b exp=1/1", step_idx, done); end
    endtask

    task automatic test_random();
        tick(0, 1, '0, '1);
        for (int s = 0; s < 120; s++) begin
            tick(($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0), N'($urandom), N'($urandom));
            checks++; if (spike_out !== m_spike) begin failures++; $display("FAIL rnd_spike cyc=%0d got=%b exp=%b", s, spike_out, m_spike); end
            checks++; if (count !== exp_count()) begin failures++; $display("FAIL rnd_count cyc=%0d got=%h exp=%h", s, count, exp_count()); end
            checks++; if (fired_cnt !== 3'($countones(m_spike))) begin failures++; $display("FAIL rnd_fired cyc=%0d got=%0d exp=%0d", s, fired_cnt, $countones(m_spike)); end
            checks++; if (step_idx !== 5'(m_step)) begin failures++; $display("FAIL rnd_step cyc=%0d got=%0d exp=%0d", s, step_idx, m_step); end
            checks++; if (done !== e_done || frame_done !== e_frame) begin failures++; $display("FAIL rnd_done cyc=%0d got=%b%b exp=%b%b", s, done, frame_done, e_done, e_frame); end
            checks++; if (f_done !== ef_done || f_frame !== ef_frame || f_step_idx !== 2'(f_step)) begin failures++; $display("FAIL rnd_frame cyc=%0d got=%b%b/%0d exp=%b%b/%0d", s, f_done, f_frame, f_step_idx, ef_done, ef_frame, f_step); end
        end
    endtask

    initial begin
        test_reset();
        test_spike();
        test_saturation();
        test_mask();
        test_frame();
        test_collision();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
